// File: rtl/hit_judge.sv
// Drum hit judge: rates a pad press against a per-note timing window (GREAT / GOOD / MISS).
// Optional build macro EMPTY_HIT_PENALTY_EN penalises presses made while no window is open.
module hit_judge #(
    parameter int WINDOW       = 24,
    parameter int GREAT_WINDOW = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       note_arrive,
    input  logic       note_type,
    input  logic       drum_don,
    input  logic       drum_ka,
    output logic       increase_score,
    output logic       decrease_score,
    output logic [1:0] judge,
    output logic       window_open
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OPEN = 1'b1;

    localparam logic [1:0] J_NONE  = 2'b00;
    localparam logic [1:0] J_GOOD  = 2'b01;
    localparam logic [1:0] J_GREAT = 2'b10;
    localparam logic [1:0] J_MISS  = 2'b11;

    localparam logic [7:0] CNT_LAST  = 8'(WINDOW - 1);
    localparam logic [7:0] GREAT_LIM = 8'(GREAT_WINDOW);

    logic [0:0] state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       cur_type, type_n;
    logic       prev_don, prev_ka;
    logic       inc_n, dec_n;
    logic [1:0] judge_n;

    logic don_edge, ka_edge, any_edge, match_hit;

    assign don_edge  = drum_don & ~prev_don;
    assign ka_edge   = drum_ka & ~prev_ka;
    assign any_edge  = don_edge | ka_edge;
    // A hit needs exactly one pad edge and it must be the latched note type.
    assign match_hit = cur_type ? (ka_edge & ~don_edge) : (don_edge & ~ka_edge);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        type_n  = cur_type;
        inc_n   = 1'b0;
        dec_n   = 1'b0;
        judge_n = judge;

        if (state == OPEN) begin
            cnt_n = cnt + 8'd1;
            if (match_hit) begin
                inc_n   = 1'b1;
                judge_n = (cnt < GREAT_LIM) ? J_GREAT : J_GOOD;
                state_n = IDLE;
            end else if (any_edge || note_arrive || cnt == CNT_LAST) begin
                dec_n   = 1'b1;
                judge_n = J_MISS;
                state_n = IDLE;
            end
            // A new note always wins the window, after the current one was judged above.
            if (note_arrive) begin
                state_n = OPEN;
                cnt_n   = 8'd0;
                type_n  = note_type;
            end
        end else begin
            if (note_arrive) begin
                state_n = OPEN;
                cnt_n   = 8'd0;
                type_n  = note_type;
            end
`ifdef EMPTY_HIT_PENALTY_EN
            if (any_edge) begin
                dec_n   = 1'b1;
                judge_n = J_MISS;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            cur_type       <= 1'b0;
            prev_don       <= 1'b1;  // a pad held through reset release must not look like a press
            prev_ka        <= 1'b1;
            increase_score <= 1'b0;
            decrease_score <= 1'b0;
            judge          <= J_NONE;
            window_open    <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            cur_type       <= type_n;
            prev_don       <= drum_don;
            prev_ka        <= drum_ka;
            increase_score <= inc_n;
            decrease_score <= dec_n;
            judge          <= judge_n;
            window_open    <= (state_n == OPEN);
        end
    end

endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: directed stimulus pushes expected pulses, a monitor pops and compares.
// Expectations follow EMPTY_HIT_PENALTY_EN when the bench is built with that macro.
module tb_hit_judge;

    logic       clk = 1'b0;
    logic       reset;
    logic       note_arrive, note_type, drum_don, drum_ka;
    logic       increase_score, decrease_score;
    logic [1:0] judge;
    logic       window_open;

    hit_judge #(.WINDOW(24), .GREAT_WINDOW(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .note_arrive    (note_arrive),
        .note_type      (note_type),
        .drum_don       (drum_don),
        .drum_ka        (drum_ka),
        .increase_score (increase_score),
        .decrease_score (decrease_score),
        .judge          (judge),
        .window_open    (window_open)
    );

    always #5 clk = ~clk;

    // Edge index; spec time "T+k" for an output registered at edge E is E+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       inc;
        logic       dec;
        logic [1:0] judge;
        logic       wo;
        int         t;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic inc, input logic dec, input logic [1:0] j, input logic wo, input int t);
        exp_t e;
        e.inc = inc; e.dec = dec; e.judge = j; e.wo = wo; e.t = t;
        exp_q.push_back(e);
    endtask

    // Inputs set here are sampled by the next rising edge, whose index is returned.
    task automatic drive(input logic arr, input logic typ, input logic don, input logic ka, output int t);
        @(negedge clk);
        note_arrive = arr;
        note_type   = typ;
        drum_don    = don;
        drum_ka     = ka;
        t           = cyc + 1;
    endtask

    task automatic idle(input int n, input logic don);
        int t;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, don, 1'b0, t);
    endtask

    task automatic expect_empty(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (increase_score === 1'b1 || decrease_score === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got inc=%0b dec=%0b judge=%0b at T=%0d expected no pulse",
                         increase_score, decrease_score, judge, cyc + 1);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_time", cyc + 1, mon_e.t);
                check("pulse_kind", {increase_score, decrease_score}, {mon_e.inc, mon_e.dec});
                check("pulse_judge", judge, mon_e.judge);
                check("pulse_window_open", window_open, mon_e.wo);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, t;
        reset = 1'b1; note_arrive = 1'b0; note_type = 1'b0; drum_don = 1'b0; drum_ka = 1'b0;
        #2;
        check("rst_outputs", {increase_score, decrease_score, judge, window_open}, 5'b0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        idle(2, 1'b0);

        // Don note, don press at T+3 -> GREAT at T+4, window closed.
        drive(1, 0, 0, 0, t0); idle(2, 0);
        drive(0, 0, 1, 0, t); push(1, 0, 2'b10, 0, t0 + 4);
        idle(4, 0); expect_empty("A_drained");
        check("A_judge_held", judge, 2'b10);
        check("A_window_closed", window_open, 1'b0);

        // Ka note, ka press at T+12 (cnt=11) -> GOOD at T+13.
        drive(1, 1, 0, 0, t0); idle(11, 0);
        drive(0, 0, 0, 1, t); push(1, 0, 2'b01, 0, t0 + 13);
        idle(4, 0); expect_empty("B_drained");

        // No press -> single MISS at T+25.
        drive(1, 0, 0, 0, t0); push(0, 1, 2'b11, 0, t0 + 25);
        idle(30, 0); expect_empty("C_drained");

        // Wrong pad at T+2 -> MISS at T+3; later don press in IDLE.
        drive(1, 0, 0, 0, t0); idle(1, 0);
        drive(0, 0, 0, 1, t); push(0, 1, 2'b11, 0, t0 + 3);
        idle(2, 0);
        drive(0, 0, 1, 0, t);
`ifdef EMPTY_HIT_PENALTY_EN
        push(0, 1, 2'b11, 0, t0 + 6);
`endif
        idle(4, 0); expect_empty("D_drained");
        check("D_judge_held", judge, 2'b11);

        // Second note at T+5 -> MISS at T+6 with window still open; restart expires at T+30.
        drive(1, 0, 0, 0, t0); idle(4, 0);
        drive(1, 1, 0, 0, t); push(0, 1, 2'b11, 1, t0 + 6); push(0, 1, 2'b11, 0, t0 + 30);
        idle(10, 0);
        check("E_window_still_open", window_open, 1'b1);
        idle(20, 0); expect_empty("E_drained");

        // GREAT/GOOD boundary: cnt=7 is GREAT, cnt=8 is GOOD.
        drive(1, 0, 0, 0, t0); idle(7, 0);
        drive(0, 0, 1, 0, t); push(1, 0, 2'b10, 0, t0 + 9);
        idle(3, 0);
        drive(1, 0, 0, 0, t0); idle(8, 0);
        drive(0, 0, 1, 0, t); push(1, 0, 2'b01, 0, t0 + 10);
        idle(3, 0); expect_empty("G_drained");

        // Simultaneous don+ka on a ka note -> MISS.
        drive(1, 1, 0, 0, t0);
        drive(0, 0, 1, 1, t); push(0, 1, 2'b11, 0, t0 + 2);
        idle(3, 0); expect_empty("H_drained");

        // Held don: one hit only; a note arriving while still held is never hit and expires.
        drive(1, 0, 0, 0, t0);
        drive(0, 0, 1, 0, t); push(1, 0, 2'b10, 0, t0 + 2);
        idle(2, 1);
        drive(1, 0, 1, 0, t1); push(0, 1, 2'b11, 0, t1 + 25);
        idle(3, 1);
        idle(30, 0); expect_empty("I_drained");

        // Matching press together with a new note: hit with window still open, then new ka note hit.
        drive(1, 0, 0, 0, t0); idle(2, 0);
        drive(1, 1, 1, 0, t); push(1, 0, 2'b10, 1, t0 + 4);
        idle(1, 0);
        drive(0, 0, 0, 1, t); push(1, 0, 2'b10, 0, t0 + 6);
        idle(4, 0); expect_empty("J_drained");

        // Don held across reset release, then reset mid-window: no pulse, async clear.
        @(negedge clk);
        drum_don = 1'b1;
        #1 reset = 1'b1;
        #1 check("F_rst_async", {increase_score, decrease_score, judge, window_open}, 5'b0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        idle(3, 1);
        drive(1, 0, 1, 0, t0);
        idle(3, 1);
        check("F_window_open", window_open, 1'b1);
        #2 reset = 1'b1;
        #1 check("F_rst_mid_window", {increase_score, decrease_score, judge, window_open}, 5'b0);
        @(negedge clk);
        drum_don = 1'b0;
        reset    = 1'b0;
        idle(30, 0); expect_empty("F_no_pulse");
        check("F_final_idle", {judge, window_open}, 3'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
